// File: rtl/lcd_ctrl_param.sv
// -----------------------------------------------------------------------------
// lcd_ctrl_param
// Character-LCD (HD44780 class) controller. After reset it waits out the
// power-up delay, runs the fixed init command sequence and then accepts
// single-byte host requests (write or read-back) while busy is low. All LCD
// timing is open-loop counted; the panel busy flag is never polled.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   cfg        {lines,font,disp_on,cursor,blink,inc_dec,shift}, latched once
//              when power-up ends
//   lcd_enable host request strobe, accepted only while busy is low
//   lcd_bus    {rs,rw,data[7:0]} of the request, latched on acceptance
//   lcd_din    LCD data pins as read back
//   busy       1 while a request would not be accepted
//   e          LCD enable strobe
//   rs, rw     LCD register select / read-not-write
//   lcd_data   LCD data pins out (0 during reads and waits)
//   rd_data    last byte read from the LCD
//   rd_valid   one-cycle pulse when rd_data is updated
//
// state   | meaning
// --------+--------------------------------------------------------------
// POWERUP | power-up delay, outputs idle, busy high
// INIT    | init commands, each as transfer unit(s) then a quiet wait
// IDLE    | ready, busy low, waiting for lcd_enable
// XFER    | host transfer: one unit (8-bit) or two nibble units (4-bit)
// -----------------------------------------------------------------------------
module lcd_ctrl_param #(
   parameter int CLK_FREQ   = 5,
   parameter int DATA_W     = 8,
   parameter int POWERUP_US = 500,
   parameter int XFER_US    = 50,
   parameter int CLEAR_US   = 200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        cfg,
   input  logic              lcd_enable,
   input  logic [9:0]        lcd_bus,
   input  logic [DATA_W-1:0] lcd_din,
   output logic              busy,
   output logic              e,
   output logic              rs,
   output logic              rw,
   output logic [DATA_W-1:0] lcd_data,
   output logic [7:0]        rd_data,
   output logic              rd_valid
);

   generate
      if (DATA_W != 4 && DATA_W != 8) begin : g_bad_width
         $error("lcd_ctrl_param: DATA_W must be 4 or 8");
      end
   endgenerate

   localparam int CBITS = $clog2(POWERUP_US*CLK_FREQ+1);

   localparam logic [CBITS-1:0] PU_LAST   = CBITS'(POWERUP_US*CLK_FREQ - 1);
   localparam logic [CBITS-1:0] XF_LAST   = CBITS'(XFER_US*CLK_FREQ - 1);
   localparam logic [CBITS-1:0] E_ON      = CBITS'(CLK_FREQ);
   localparam logic [CBITS-1:0] E_OFF     = CBITS'(14*CLK_FREQ);
   localparam logic [CBITS-1:0] E_LAST    = CBITS'(14*CLK_FREQ - 1);
   localparam logic [CBITS-1:0] W_FSET_L  = CBITS'(50*CLK_FREQ - 1);
   localparam logic [CBITS-1:0] W_DISP_L  = CBITS'(50*CLK_FREQ - 1);
   localparam logic [CBITS-1:0] W_CLEAR_L = CBITS'(CLEAR_US*CLK_FREQ - 1);
   localparam logic [CBITS-1:0] W_ENTRY_L = CBITS'(100*CLK_FREQ - 1);

   localparam logic       NIB        = (DATA_W == 4);
   // Steps 0..3 are the 4-bit wake-up nibbles; byte mode starts at fset.
   localparam logic [2:0] FIRST_STEP = NIB ? 3'd0 : 3'd4;

   typedef enum logic [1:0] {S_POWERUP, S_INIT, S_IDLE, S_XFER} state_t;

   state_t            state_q, state_d;
   logic [CBITS-1:0]  cnt_q, cnt_d;
   logic [2:0]        step_q, step_d;
   logic              half_q, half_d;
   logic              wait_q, wait_d;
   logic [6:0]        cfg_q, cfg_d;
   logic [9:0]        bus_q, bus_d;
   logic [7:0]        rdbuf_q, rdbuf_d;
   logic              busy_q, busy_d;
   logic              e_q, e_d;
   logic              rs_q, rs_d;
   logic              rw_q, rw_d;
   logic [DATA_W-1:0] lcd_data_q, lcd_data_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   function automatic logic [7:0] step_byte(input logic [2:0] step, input logic [6:0] c);
      logic [7:0] b;
      case (step)
         3'd0, 3'd1, 3'd2: b = 8'h30;
         3'd3:             b = 8'h20;
         3'd4:             b = {3'b001, ~NIB, c[6], c[5], 2'b00};
         3'd5:             b = {5'b00001, c[4], c[3], c[2]};
         3'd6:             b = 8'h01;
         default:          b = {6'b000001, c[1], c[0]};
      endcase
      return b;
   endfunction

   function automatic logic [CBITS-1:0] step_wait_last(input logic [2:0] step);
      logic [CBITS-1:0] w;
      case (step)
         3'd4:    w = W_FSET_L;
         3'd5:    w = W_DISP_L;
         3'd6:    w = W_CLEAR_L;
         default: w = W_ENTRY_L;
      endcase
      return w;
   endfunction

   // In nibble mode the first unit carries the high nibble.
   function automatic logic [DATA_W-1:0] unit_data(input logic [7:0] b, input logic h);
      logic [7:0] sel;
      sel = (NIB && !h) ? {4'h0, b[7:4]} : b;
      return sel[DATA_W-1:0];
   endfunction

   logic [CBITS-1:0] cnt_inc;
   logic [7:0]       din8;
   logic             in_unit;

   assign cnt_inc = cnt_q + CBITS'(1);
   assign din8    = 8'(lcd_din);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      step_d     = step_q;
      half_d     = half_q;
      wait_d     = wait_q;
      cfg_d      = cfg_q;
      bus_d      = bus_q;
      rdbuf_d    = rdbuf_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;

      case (state_q)
         S_POWERUP: begin
            if (cnt_q == PU_LAST) begin
               state_d = S_INIT;
               cnt_d   = '0;
               step_d  = FIRST_STEP;
               half_d  = 1'b0;
               wait_d  = 1'b0;
               cfg_d   = cfg;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         S_INIT: begin
            cnt_d = cnt_inc;
            if ((!wait_q && cnt_q == XF_LAST && step_q >= 3'd4 && NIB && !half_q)) begin
               cnt_d  = '0;
               half_d = 1'b1;
            end else if (!wait_q && cnt_q == XF_LAST && step_q >= 3'd4) begin
               cnt_d  = '0;
               wait_d = 1'b1;
            end else if ((!wait_q && cnt_q == XF_LAST) ||
                         (wait_q && cnt_q == step_wait_last(step_q))) begin
               cnt_d  = '0;
               half_d = 1'b0;
               wait_d = 1'b0;
               if (step_q == 3'd7) state_d = S_IDLE;
               else                step_d  = step_q + 3'd1;
            end
         end

         S_IDLE: begin
            if (lcd_enable) begin
               bus_d   = lcd_bus;
               state_d = S_XFER;
               cnt_d   = '0;
               half_d  = 1'b0;
               rdbuf_d = 8'h00;
            end
         end

         S_XFER: begin
            cnt_d = cnt_inc;
            // Read data is captured on the last cycle e is high.
            if (bus_q[8] && cnt_q == E_LAST) begin
               if (!NIB)        rdbuf_d = din8;
               else if (!half_q) rdbuf_d = {din8[3:0], rdbuf_q[3:0]};
               else             rdbuf_d = {rdbuf_q[7:4], din8[3:0]};
            end
            if (cnt_q == XF_LAST) begin
               cnt_d = '0;
               if (NIB && !half_q) begin
                  half_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  half_d  = 1'b0;
                  if (bus_q[8]) begin
                     rd_data_d  = rdbuf_d;
                     rd_valid_d = 1'b1;
                  end
               end
            end
         end

         default: state_d = S_POWERUP;
      endcase

      // Outputs are decoded from the next state so they land on the same
      // edge as the state change.
      in_unit    = (state_d == S_INIT && !wait_d) || (state_d == S_XFER);
      busy_d     = (state_d != S_IDLE);
      e_d        = in_unit && (cnt_d >= E_ON) && (cnt_d < E_OFF);
      rs_d       = (state_d == S_XFER) && bus_d[9];
      rw_d       = (state_d == S_XFER) && bus_d[8];
      lcd_data_d = '0;
      if (state_d == S_INIT && !wait_d)
         lcd_data_d = unit_data(step_byte(step_d, cfg_d), half_d);
      else if (state_d == S_XFER && !bus_d[8])
         lcd_data_d = unit_data(bus_d[7:0], half_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_POWERUP;
         cnt_q      <= '0;
         step_q     <= FIRST_STEP;
         half_q     <= 1'b0;
         wait_q     <= 1'b0;
         cfg_q      <= 7'h00;
         bus_q      <= 10'h000;
         rdbuf_q    <= 8'h00;
         busy_q     <= 1'b1;
         e_q        <= 1'b0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         lcd_data_q <= '0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         step_q     <= step_d;
         half_q     <= half_d;
         wait_q     <= wait_d;
         cfg_q      <= cfg_d;
         bus_q      <= bus_d;
         rdbuf_q    <= rdbuf_d;
         busy_q     <= busy_d;
         e_q        <= e_d;
         rs_q       <= rs_d;
         rw_q       <= rw_d;
         lcd_data_q <= lcd_data_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign busy     = busy_q;
   assign e        = e_q;
   assign rs       = rs_q;
   assign rw       = rw_q;
   assign lcd_data = lcd_data_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_lcd_ctrl_param
// Drives a byte-mode and a nibble-mode instance of lcd_ctrl_param. The
// expected pin activity is described as a list of segments (transfer units
// and quiet waits) built from the LCD protocol rules, and every cycle of a
// segment is compared against the instance outputs.
// -----------------------------------------------------------------------------
module tb_lcd_ctrl_param;

   localparam int CF = 5;
   localparam int XF = 50*CF;
   localparam int PU = 500*CF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst8, rst4;
   logic [6:0] cfg;
   logic       en;
   logic [9:0] bus;
   logic [7:0] din8;
   logic [3:0] din4;

   logic       busy8, e8, rs8, rw8, rdv8;
   logic [7:0] data8, rdd8;
   logic       busy4, e4, rs4, rw4, rdv4;
   logic [3:0] data4;
   logic [7:0] rdd4;

   lcd_ctrl_param #(.DATA_W(8)) u_dut8 (
      .clk(clk), .rst(rst8), .cfg(cfg), .lcd_enable(en), .lcd_bus(bus),
      .lcd_din(din8), .busy(busy8), .e(e8), .rs(rs8), .rw(rw8),
      .lcd_data(data8), .rd_data(rdd8), .rd_valid(rdv8));

   lcd_ctrl_param #(.DATA_W(4)) u_dut4 (
      .clk(clk), .rst(rst4), .cfg(cfg), .lcd_enable(en), .lcd_bus(bus),
      .lcd_din(din4), .busy(busy4), .e(e4), .rs(rs4), .rw(rw4),
      .lcd_data(data4), .rd_data(rdd4), .rd_valid(rdv4));

   typedef struct {
      int         len;
      bit         unit;
      bit         rs;
      bit         rw;
      logic [7:0] data;
      logic [7:0] din;
   } seg_t;

   seg_t       q[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] last_rd8 = 8'h00;
   logic [7:0] last_rd4 = 8'h00;

   function automatic logic [31:0] pack(input bit b, input bit ee, input bit r, input bit w,
                                        input bit v, input logic [7:0] d, input logic [7:0] rd);
      return {11'b0, b, ee, r, w, v, d, rd};
   endfunction

   function automatic logic [31:0] obs(input bit sel);
      if (sel) return pack(busy4, e4, rs4, rw4, rdv4, {4'h0, data4}, rdd4);
      return pack(busy8, e8, rs8, rw8, rdv8, data8, rdd8);
   endfunction

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] x);
      vectors++;
      assert (o === x) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (busy,e,rs,rw,rdv,data,rd_data)", tag, o, x);
      end
   endtask

   task automatic push_unit(input bit r, input bit w, input logic [7:0] d, input logic [7:0] di);
      seg_t s;
      s = '{XF, 1'b1, r, w, d, di};
      q.push_back(s);
   endtask

   task automatic push_wait(input int n);
      seg_t s;
      s = '{n, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      q.push_back(s);
   endtask

   // One LCD byte: a single unit in byte mode, high then low nibble otherwise.
   task automatic push_byte(input bit sel, input bit r, input bit w,
                            input logic [7:0] b, input logic [7:0] di);
      if (sel) begin
         push_unit(r, w, w ? 8'h00 : {4'h0, b[7:4]}, {4'h0, di[7:4]});
         push_unit(r, w, w ? 8'h00 : {4'h0, b[3:0]}, {4'h0, di[3:0]});
      end else begin
         push_unit(r, w, w ? 8'h00 : b, di);
      end
   endtask

   task automatic build_init(input bit sel, input logic [6:0] c);
      push_wait(PU);
      if (sel) begin
         push_unit(0, 0, 8'h03, 8'h00);
         push_unit(0, 0, 8'h03, 8'h00);
         push_unit(0, 0, 8'h03, 8'h00);
         push_unit(0, 0, 8'h02, 8'h00);
      end
      push_byte(sel, 0, 0, {3'b001, ~sel, c[6], c[5], 2'b00}, 8'h00);
      push_wait(50*CF);
      push_byte(sel, 0, 0, {5'b00001, c[4], c[3], c[2]}, 8'h00);
      push_wait(50*CF);
      push_byte(sel, 0, 0, 8'h01, 8'h00);
      push_wait(200*CF);
      push_byte(sel, 0, 0, {6'b000001, c[1], c[0]}, 8'h00);
      push_wait(100*CF);
   endtask

   // Walks the queued segments one cycle at a time from the current negedge.
   // noise toggles lcd_enable (and cfg after power-up) to show they are ignored.
   task automatic run_segments(input bit sel, input int limit, input bit noise, input string tag);
      int         n;
      bit         stop;
      bit         ee;
      logic [7:0] lrd;
      n    = 0;
      stop = 0;
      lrd  = sel ? last_rd4 : last_rd8;
      foreach (q[i]) begin
         for (int k = 0; k < q[i].len && !stop; k++) begin
            if (limit > 0 && n >= limit) begin
               stop = 1;
            end else begin
               ee = q[i].unit && (k >= CF) && (k < 14*CF);
               check(tag, obs(sel), pack(1'b1, ee, q[i].rs, q[i].rw, 1'b0, q[i].data, lrd));
               if (q[i].unit && q[i].rw && k == 14*CF-1) begin
                  din8 = q[i].din;
                  din4 = q[i].din[3:0];
               end else begin
                  din8 = 8'($urandom);
                  din4 = 4'($urandom);
               end
               if (noise) begin
                  en = 1'($urandom);
                  if (i > 0) cfg = 7'($urandom);
               end
               @(negedge clk);
               n++;
            end
         end
      end
      q.delete();
      en = 1'b0;
   endtask

   task automatic do_reset(input bit sel, input logic [6:0] c);
      if (sel) rst4 = 1'b1; else rst8 = 1'b1;
      @(negedge clk);
      check("reset", obs(sel), pack(1, 0, 0, 0, 0, 8'h00, 8'h00));
      repeat (2) @(negedge clk);
      cfg = c;
      if (sel) begin rst4 = 1'b0; last_rd4 = 8'h00; end
      else     begin rst8 = 1'b0; last_rd8 = 8'h00; end
      build_init(sel, c);
      run_segments(sel, 0, 1, "init");
      check("init_done", obs(sel), pack(0, 0, 0, 0, 0, 8'h00, 8'h00));
   endtask

   task automatic xact(input bit sel, input logic [9:0] b, input logic [7:0] di, input bit noise);
      logic [7:0] lrd;
      push_byte(sel, b[9], b[8], b[7:0], di);
      bus = b;
      en  = 1'b1;
      @(negedge clk);
      en  = 1'b0;
      bus = 10'($urandom);
      run_segments(sel, 0, noise, "xfer");
      if (b[8]) begin
         if (sel) last_rd4 = di; else last_rd8 = di;
      end
      lrd = sel ? last_rd4 : last_rd8;
      check("xfer_end", obs(sel), pack(0, 0, 0, 0, b[8], 8'h00, lrd));
      @(negedge clk);
      check("idle_hold", obs(sel), pack(0, 0, 0, 0, 0, 8'h00, lrd));
   endtask

   initial begin
      rst8 = 1'b1;
      rst4 = 1'b1;
      cfg  = 7'h00;
      en   = 1'b0;
      bus  = 10'h000;
      din8 = 8'h00;
      din4 = 4'h0;

      // Byte-mode instance
      do_reset(0, 7'h7F);
      xact(0, 10'h241, 8'h00, 0);
      xact(0, 10'h100, 8'hC3, 1);
      repeat (6) xact(0, 10'($urandom), 8'($urandom), 1);

      // Reset while e is high in the middle of a write, then full re-init
      push_byte(0, 1, 0, 8'h5A, 8'h00);
      bus = 10'h25A;
      en  = 1'b1;
      @(negedge clk);
      en  = 1'b0;
      run_segments(0, 20, 0, "xfer_pre_rst");
      #2 rst8 = 1'b1;
      #1 check("rst_mid", obs(0), pack(1, 0, 0, 0, 0, 8'h00, 8'h00));
      do_reset(0, 7'($urandom));
      xact(0, 10'($urandom), 8'($urandom), 1);
      rst8 = 1'b1;

      // Nibble-mode instance
      do_reset(1, 7'($urandom));
      xact(1, 10'h241, 8'h00, 0);
      xact(1, 10'h300, 8'hA5, 0);
      repeat (6) xact(1, 10'($urandom), 8'($urandom), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
